// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin arbiter and safe s/r/en sequencer for a bank of
// gated SR latches. Keeps a shadow copy of the last value written to each latch.
// Optional readback check of q during HOLD is enabled by defining
// SR_BANK_CTRL_VERIFY_EN; without it q is ignored and err is tied low.
module sr_bank_ctrl #(
  parameter int NREQ      = 2,
  parameter int NLATCH    = 4,
  parameter int IDXW      = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   idx_err,
  output logic                   busy,
  output logic [NLATCH-1:0]      s,
  output logic [NLATCH-1:0]      r,
  output logic [NLATCH-1:0]      en,
  input  logic [NLATCH-1:0]      q,
  output logic [NLATCH-1:0]      shadow,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RELEASE} state_t;

  state_t state, next_state;

  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   w_q;
  logic            op_q;
  logic [IDXW-1:0] idx_q;

  logic            any_req;
  logic [PW-1:0]   arb_w;
  logic            arb_op;
  logic [IDXW-1:0] arb_idx;

  logic [PW-1:0]   cur_w;
  logic            cur_op;
  logic [IDXW-1:0] cur_idx;
  logic            cur_valid;
  logic [NLATCH-1:0] sel_mask;
  logic [NREQ-1:0]   w_mask;

  logic [NREQ-1:0]   gnt_d;
  logic [NREQ-1:0]   done_d;
  logic [NLATCH-1:0] s_d;
  logic [NLATCH-1:0] r_d;
  logic [NLATCH-1:0] en_d;
  logic [NLATCH-1:0] shadow_d;
  logic              idx_err_d;
  logic              busy_d;
  logic              drive;

  // Round-robin pick: first pending requester searching upward from ptr+1.
  always_comb begin
    int j;
    logic found;
    j       = 0;
    found   = 1'b0;
    any_req = |req;
    arb_w   = '0;
    arb_op  = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == j) && req[i]) begin
          found   = 1'b1;
          arb_w   = PW'(i);
          arb_op  = op[i];
          arb_idx = idx[i*IDXW +: IDXW];
        end
      end
    end
  end

  // Transaction being issued: the fresh arbitration winner in IDLE, the latched one otherwise.
  always_comb begin
    cur_w    = (state == IDLE) ? arb_w   : w_q;
    cur_op   = (state == IDLE) ? arb_op  : op_q;
    cur_idx  = (state == IDLE) ? arb_idx : idx_q;
    sel_mask = '0;
    w_mask   = '0;
    for (int i = 0; i < NLATCH; i++) begin
      sel_mask[i] = (int'(cur_idx) == i);
    end
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (int'(cur_w) == i);
    end
    cur_valid = |sel_mask;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a bad index skips the pulse and goes straight to RELEASE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = SETUP;
      SETUP:   next_state = cur_valid ? PULSE : RELEASE;
      PULSE:   if (cnt == CW'(PULSE_CYC - 1)) next_state = HOLD;
      HOLD:    next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values for the upcoming state, so every output can be registered.
  always_comb begin
    drive     = (next_state == SETUP) || (next_state == PULSE) || (next_state == HOLD);
    gnt_d     = (next_state == SETUP) ? w_mask : '0;
    done_d    = (next_state == RELEASE) ? w_mask : '0;
    s_d       = (drive && cur_op)  ? sel_mask : '0;
    r_d       = (drive && !cur_op) ? sel_mask : '0;
    en_d      = (next_state == PULSE) ? sel_mask : '0;
    idx_err_d = (next_state == RELEASE) && !cur_valid;
    busy_d    = (next_state != IDLE);
    shadow_d  = shadow;
    if ((next_state == RELEASE) && (state != RELEASE)) begin
      shadow_d = (shadow & ~sel_mask) | (cur_op ? sel_mask : '0);
    end
  end

  // Transaction registers, pulse counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= PW'(NREQ - 1);
      cnt   <= '0;
      w_q   <= '0;
      op_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        w_q   <= arb_w;
        op_q  <= arb_op;
        idx_q <= arb_idx;
      end
      cnt <= (state == PULSE) ? cnt + CW'(1) : '0;
      if (state == RELEASE) begin
        ptr <= w_q;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      done    <= '0;
      s       <= '0;
      r       <= '0;
      en      <= '0;
      shadow  <= '0;
      idx_err <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt     <= gnt_d;
      done    <= done_d;
      s       <= s_d;
      r       <= r_d;
      en      <= en_d;
      shadow  <= shadow_d;
      idx_err <= idx_err_d;
      busy    <= busy_d;
    end
  end

`ifdef SR_BANK_CTRL_VERIFY_EN
  // Sticky readback check: the addressed latch must hold op by the HOLD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == HOLD && |(sel_mask & (q ^ {NLATCH{op_q}}))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_q;
  assign unused_q = ^q;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: directed and randomized bench for sr_bank_ctrl with a
// transaction-level reference model (phase offset within each served request).
module tb_sr_bank_ctrl;

  localparam int NREQ      = 2;
  localparam int NLATCH    = 3;
  localparam int IDXW      = 2;
  localparam int PULSE_CYC = 2;
  localparam int VALID_LEN = PULSE_CYC + 3;
  localparam int BAD_LEN   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      op = '0;
  logic [NREQ*IDXW-1:0] idx = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 idx_err;
  logic                 busy;
  logic [NLATCH-1:0]    s;
  logic [NLATCH-1:0]    r;
  logic [NLATCH-1:0]    en;
  logic [NLATCH-1:0]    q;
  logic [NLATCH-1:0]    shadow;
  logic                 err;

  logic [NLATCH-1:0]    lq = '0;
  logic                 force_q1 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  bit                m_active;
  int                m_k;
  int                m_len;
  int                m_w;
  bit                m_op;
  int                m_idx;
  bit                m_valid;
  int                m_ptr;
  logic [NLATCH-1:0] m_shadow;
  bit                m_err;

  logic [NLATCH-1:0] prev_s;
  logic [NLATCH-1:0] prev_r;
  logic [NLATCH-1:0] prev_en;
  logic [NREQ-1:0]   gnt_log[$];

  always #5 clk = ~clk;

  sr_bank_ctrl #(
    .NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW), .PULSE_CYC(PULSE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .done(done), .idx_err(idx_err), .busy(busy),
    .s(s), .r(r), .en(en), .q(q), .shadow(shadow), .err(err)
  );

  // Behavioural gated SR latches so q follows the bank drive while enabled.
  always @(s or r or en) begin
    for (int i = 0; i < NLATCH; i++) begin
      if (en[i]) begin
        if (s[i]) lq[i] = 1'b1;
        else if (r[i]) lq[i] = 1'b0;
      end
    end
  end

  assign q = force_q1 ? (lq & ~NLATCH'(2)) : lq;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] rq);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (rq[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_len    = 0;
    m_ptr    = NREQ - 1;
    m_shadow = '0;
    m_err    = 1'b0;
    prev_s   = '0;
    prev_r   = '0;
    prev_en  = '0;
  endtask

  task automatic model_advance();
    if (m_active) begin
      m_k++;
      if (m_k > m_len) begin
        m_active = 1'b0;
        m_k      = 0;
      end else if (m_k == m_len && m_valid) begin
        m_shadow[m_idx] = m_op;
        if (force_q1 && m_idx == 1 && m_op) m_err = 1'b1;
      end
    end else if (req != '0) begin
      m_w      = rr_pick(m_ptr, req);
      m_ptr    = m_w;
      m_op     = op[m_w];
      m_idx    = int'(idx[m_w*IDXW +: IDXW]);
      m_valid  = (m_idx < NLATCH);
      m_len    = m_valid ? VALID_LEN : BAD_LEN;
      m_active = 1'b1;
      m_k      = 1;
    end
  endtask

  task automatic expect_outputs();
    logic [NLATCH-1:0] one_idx;
    logic [NREQ-1:0]   one_w;
    bit                sr_on;
    bit                en_on;
    bit                fin;
    one_idx = m_valid ? (NLATCH'(1) << m_idx) : '0;
    one_w   = NREQ'(1) << m_w;
    sr_on   = m_active && m_valid && (m_k >= 1) && (m_k <= PULSE_CYC + 2);
    en_on   = m_active && m_valid && (m_k >= 2) && (m_k <= PULSE_CYC + 1);
    fin     = m_active && (m_k == m_len);
    check_output("gnt",     gnt,     (m_active && m_k == 1) ? one_w : '0);
    check_output("done",    done,    fin ? one_w : '0);
    check_output("idx_err", idx_err, fin && !m_valid);
    check_output("busy",    busy,    m_active);
    check_output("s",       s,       (sr_on && m_op)  ? one_idx : '0);
    check_output("r",       r,       (sr_on && !m_op) ? one_idx : '0);
    check_output("en",      en,      en_on ? one_idx : '0);
    check_output("shadow",  shadow,  m_shadow);
`ifdef SR_BANK_CTRL_VERIFY_EN
    check_output("err",     err,     m_err);
`else
    check_output("err",     err,     1'b0);
`endif
    check_output("s_and_r_zero", s & r, '0);
    check_output("en_onehot0", $onehot0(en), 1'b1);
    if (prev_en != '0 && en != '0) begin
      check_output("s_stable_while_en", s, prev_s);
      check_output("r_stable_while_en", r, prev_r);
    end
    if ((prev_s | prev_r) != '0 && (s | r) == '0) begin
      check_output("sr_drop_after_en_low", prev_en, '0);
    end
    prev_s  = s;
    prev_r  = r;
    prev_en = en;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_advance();
    #1;
    expect_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_output("rst_gnt",     gnt,     '0);
    check_output("rst_done",    done,    '0);
    check_output("rst_idx_err", idx_err, 1'b0);
    check_output("rst_busy",    busy,    1'b0);
    check_output("rst_s",       s,       '0);
    check_output("rst_r",       r,       '0);
    check_output("rst_en",      en,      '0);
    check_output("rst_shadow",  shadow,  '0);
    check_output("rst_err",     err,     1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input bit o, input int ix);
    req[i] = 1'b1;
    op[i]  = o;
    idx[i*IDXW +: IDXW] = IDXW'(ix);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (m_active && m_k == 1 && m_w == i) begin
        req[i] = 1'b0;
      end else if (!req[i]) begin
        if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end else if ($urandom_range(0, 39) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #1;
    do_reset();

    // Single set of latch 2 from requester 0.
    set_req(0, 1'b1, 2);
    run_cycle();
    check_output("t1_gnt", gnt, 2'b01);
    req = '0;
    repeat (4) run_cycle();
    check_output("t1_done", done, 2'b01);
    check_output("t1_shadow", shadow, 3'b100);
    repeat (2) run_cycle();
    check_output("t1_idle_s", s | r | en, '0);

    // Contention on latch 0 with opposite ops, from a fresh pointer.
    #2;
    do_reset();
    set_req(0, 1'b1, 0);
    set_req(1, 1'b0, 0);
    gnt_log.delete();
    for (int c = 0; c < 23; c++) begin
      run_cycle();
      if (gnt != '0) gnt_log.push_back(gnt);
    end
    check_output("t2_shadow0", shadow[0], 1'b0);
    req = '0;
    repeat (3) run_cycle();
    check_output("t2_gnt_count", gnt_log.size(), 4);
    if (gnt_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check_output("t2_gnt_order", gnt_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end

    // Bad index on a 3-latch bank.
    set_req(0, 1'b1, 3);
    run_cycle();
    check_output("t3_gnt", gnt, 2'b01);
    req = '0;
    run_cycle();
    check_output("t3_done", done, 2'b01);
    check_output("t3_idx_err", idx_err, 1'b1);
    check_output("t3_shadow", shadow, 3'b000);
    repeat (2) run_cycle();

    // Reset while latch 1 is being pulsed.
    set_req(1, 1'b1, 1);
    run_cycle();
    req = '0;
    run_cycle();
    check_output("t4_en_pre", en, 3'b010);
    #2;
    do_reset();
    set_req(0, 1'b0, 1);
    run_cycle();
    check_output("t4_gnt_after", gnt, 2'b01);
    req = '0;
    repeat (6) run_cycle();

    // Readback of latch 1 forced low during a set.
    force_q1 = 1'b1;
    set_req(0, 1'b1, 1);
    run_cycle();
    req = '0;
    repeat (4) run_cycle();
`ifdef SR_BANK_CTRL_VERIFY_EN
    check_output("t6_err_set", err, 1'b1);
`else
    check_output("t6_err_off", err, 1'b0);
`endif
    run_cycle();
    force_q1 = 1'b0;
    set_req(1, 1'b0, 2);
    run_cycle();
    req = '0;
    repeat (6) run_cycle();
`ifdef SR_BANK_CTRL_VERIFY_EN
    check_output("t6_err_sticky", err, 1'b1);
`else
    check_output("t6_err_off2", err, 1'b0);
`endif

    // Randomized traffic with every-cycle safety and model checks.
    for (int c = 0; c < 1000; c++) begin
      apply_stimulus();
      run_cycle();
    end
    req = '0;
    repeat (8) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
